sspm_tdm_backbone: RTL and testbench

// - Shared-scratchpad backbone stage downstream of the per-core SSPM connectors.
// - Collects one OCP request per core, grants the single shared SRAM port by TDM round-robin,
//   and returns read data / write ack to the originating core.
// - Sits between the NCORES connector outputs and one synchronous single-port SRAM (1-cycle read).

---
 rtl/sspm_pkg.sv | 24 ++
 rtl/sspm_core_port.sv | 117 +++++++++++
 rtl/sspm_tdm_backbone.sv | 115 +++++++++++
 tb/tb_sspm_tdm_backbone.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sspm_pkg.sv
// Shared constants for the SSPM TDM backbone: OCP command/response codes and
// the per-core port FSM state encoding.
package sspm_pkg;

  localparam logic [2:0] OCP_CMD_IDLE = 3'd0;
  localparam logic [2:0] OCP_CMD_WR   = 3'd1;
  localparam logic [2:0] OCP_CMD_RD   = 3'd2;

  localparam logic [1:0] OCP_RESP_NULL = 2'd0;
  localparam logic [1:0] OCP_RESP_DVA  = 2'd1;
  localparam logic [1:0] OCP_RESP_ERR  = 2'd3;

  typedef enum logic [1:0] {
    PORT_IDLE = 2'd0,
    PORT_WAIT = 2'd1,
    PORT_RESP = 2'd2
  } port_state_e;

  // True when a word address lies inside the supervisor-only low region.
  function automatic logic in_prot_region(input logic [31:0] word, input int unsigned prot_w);
    return (word >> prot_w) == 32'd0;
  endfunction

endpackage

// File: rtl/sspm_core_port.sv
// One core's request port: latches an OCP command while idle, waits for its
// TDM slot, presents the request to the SRAM mux for that single cycle, then
// answers the core for exactly one cycle.
// Optional: SSPM_PROT_EN blocks user-mode writes into the low protected region.
// Optional: SSPM_OCP_ASSERT checks that cores do not issue commands while busy.
module sspm_core_port
  import sspm_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32,
  parameter int PROT_W = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                slot_hit_i,
  input  logic [2:0]          cmd_i,
  input  logic [31:0]         addr_i,
  input  logic [DATA_W-1:0]   data_i,
  input  logic [DATA_W/8-1:0] byteen_i,
  input  logic                super_i,
  input  logic [DATA_W-1:0]   mem_rdata_i,
  output logic                req_en_o,
  output logic                req_we_o,
  output logic [ADDR_W-1:0]   req_addr_o,
  output logic [DATA_W-1:0]   req_wdata_o,
  output logic [DATA_W/8-1:0] req_byteen_o,
  output logic [1:0]          resp_o,
  output logic [DATA_W-1:0]   rdata_o
);

  port_state_e         state_q, state_d;
  logic                accept;
  logic                wr_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W/8-1:0] byteen_q;
  logic                blocked;
  logic                unused_addr_bits;

  // Commands arriving while a request is pending are dropped on the floor.
  assign accept = (state_q == PORT_IDLE) && (cmd_i != OCP_CMD_IDLE);

  // Byte-offset and above-capacity address bits carry no meaning here.
  assign unused_addr_bits = ^{addr_i[31:ADDR_W+2], addr_i[1:0]};

  // FSM state register; reset discards any pending or in-flight request.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= PORT_IDLE;
    else       state_q <= state_d;
  end

  // Request latch, loaded only when a command is accepted.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      wr_q     <= (cmd_i == OCP_CMD_WR);
      addr_q   <= addr_i[ADDR_W+1:2];
      wdata_q  <= data_i;
      byteen_q <= byteen_i;
    end
  end

`ifdef SSPM_PROT_EN
  logic super_q;

  // Supervisor flag captured together with the command.
  always_ff @(posedge clk_i) begin
    if (accept) super_q <= super_i;
  end

  assign blocked = wr_q && !super_q && in_prot_region(32'(addr_q), PROT_W);
`else
  logic unused_super;

  assign unused_super = super_i;
  assign blocked      = 1'b0;
`endif

  // Next-state and per-cycle request/response outputs.
  always_comb begin
    state_d  = state_q;
    req_en_o = 1'b0;
    req_we_o = 1'b0;
    resp_o   = OCP_RESP_NULL;
    rdata_o  = '0;
    case (state_q)
      PORT_IDLE: begin
        if (accept) state_d = PORT_WAIT;
      end
      PORT_WAIT: begin
        if (slot_hit_i) begin
          // A blocked write still consumes its slot but never reaches the SRAM.
          req_en_o = !blocked;
          req_we_o = wr_q && !blocked;
          state_d  = PORT_RESP;
        end
      end
      PORT_RESP: begin
        resp_o  = blocked ? OCP_RESP_ERR : OCP_RESP_DVA;
        rdata_o = wr_q ? '0 : mem_rdata_i;
        state_d = PORT_IDLE;
      end
      default: state_d = PORT_IDLE;
    endcase
  end

  assign req_addr_o   = addr_q;
  assign req_wdata_o  = wdata_q;
  assign req_byteen_o = byteen_q;

`ifdef SSPM_OCP_ASSERT
  // A core must wait for its response before issuing the next command.
  a_no_cmd_while_busy : assert property (
    @(posedge clk_i) disable iff (rst_i)
    (state_q != PORT_IDLE) |-> (cmd_i == OCP_CMD_IDLE));
`endif

endmodule

// File: rtl/sspm_tdm_backbone.sv
// Shared-scratchpad backbone: one request port per core, a free-running TDM
// slot counter, and the mux onto the single synchronous SRAM port.
// Optional: SSPM_PROT_EN enables supervisor-only writes to the low region.
module sspm_tdm_backbone
  import sspm_pkg::*;
#(
  parameter int NCORES = 3,
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32,
  parameter int PROT_W = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NCORES-1:0]          io_superMode,
  input  logic [3*NCORES-1:0]        io_ocp_M_Cmd,
  input  logic [32*NCORES-1:0]       io_ocp_M_Addr,
  input  logic [DATA_W*NCORES-1:0]   io_ocp_M_Data,
  input  logic [DATA_W/8*NCORES-1:0] io_ocp_M_ByteEn,
  output logic [2*NCORES-1:0]        io_ocp_S_Resp,
  output logic [DATA_W*NCORES-1:0]   io_ocp_S_Data,
  output logic                       mem_en,
  output logic                       mem_we,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [DATA_W-1:0]          mem_wdata,
  output logic [DATA_W/8-1:0]        mem_byteen,
  input  logic [DATA_W-1:0]          mem_rdata
);

  localparam int BE_W   = DATA_W / 8;
  localparam int SLOT_W = (NCORES > 1) ? $clog2(NCORES) : 1;

  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [NCORES-1:0] slot_hit;
  logic [NCORES-1:0] req_en;
  logic [NCORES-1:0] req_we;
  logic [ADDR_W-1:0] req_addr   [NCORES];
  logic [DATA_W-1:0] req_wdata  [NCORES];
  logic [BE_W-1:0]   req_byteen [NCORES];

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [BE_W-1:0]   byteen_q, byteen_d;

  // Slot advances every cycle whether or not anyone is waiting.
  assign slot_d = (slot_q == SLOT_W'(NCORES - 1)) ? '0 : slot_q + 1'b1;

  // Slot counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) slot_q <= '0;
    else       slot_q <= slot_d;
  end

  for (genvar i = 0; i < NCORES; i++) begin : g_port
    assign slot_hit[i] = (slot_q == SLOT_W'(i));

    sspm_core_port #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .PROT_W (PROT_W)
    ) u_port (
      .clk_i        (clk),
      .rst_i        (reset),
      .slot_hit_i   (slot_hit[i]),
      .cmd_i        (io_ocp_M_Cmd[3*i +: 3]),
      .addr_i       (io_ocp_M_Addr[32*i +: 32]),
      .data_i       (io_ocp_M_Data[DATA_W*i +: DATA_W]),
      .byteen_i     (io_ocp_M_ByteEn[BE_W*i +: BE_W]),
      .super_i      (io_superMode[i]),
      .mem_rdata_i  (mem_rdata),
      .req_en_o     (req_en[i]),
      .req_we_o     (req_we[i]),
      .req_addr_o   (req_addr[i]),
      .req_wdata_o  (req_wdata[i]),
      .req_byteen_o (req_byteen[i]),
      .resp_o       (io_ocp_S_Resp[2*i +: 2]),
      .rdata_o      (io_ocp_S_Data[DATA_W*i +: DATA_W])
    );
  end

  // SRAM mux: slot ownership makes req_en one-hot, so at most one core drives.
  always_comb begin
    mem_en   = 1'b0;
    mem_we   = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    byteen_d = byteen_q;
    for (int k = 0; k < NCORES; k++) begin
      if (req_en[k]) begin
        mem_en   = 1'b1;
        mem_we   = req_we[k];
        addr_d   = req_addr[k];
        wdata_d  = req_wdata[k];
        byteen_d = req_byteen[k];
      end
    end
  end

  // Keep the last driven address/data/mask on the bus during idle slots.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q   <= '0;
      wdata_q  <= '0;
      byteen_q <= '0;
    end else begin
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      byteen_q <= byteen_d;
    end
  end

  assign mem_addr   = addr_d;
  assign mem_wdata  = wdata_d;
  assign mem_byteen = byteen_d;

endmodule

// File: tb/tb_sspm_tdm_backbone.sv
// Directed bench for sspm_tdm_backbone (NCORES=3, ADDR_W=12) with a behavioural
// single-port SRAM returning read data one cycle after the access.
module tb_sspm_tdm_backbone;

  localparam int NC = 3;
  localparam int AW = 12;
  localparam int DW = 32;

  localparam logic [2:0] C_IDLE = 3'd0;
  localparam logic [2:0] C_WR   = 3'd1;
  localparam logic [2:0] C_RD   = 3'd2;
  localparam logic [1:0] R_NULL = 2'd0;
  localparam logic [1:0] R_DVA  = 2'd1;
  localparam logic [1:0] R_ERR  = 2'd3;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [NC-1:0]     super_v = '0;
  logic [3*NC-1:0]   cmd_v = '0;
  logic [32*NC-1:0]  addr_v = '0;
  logic [DW*NC-1:0]  data_v = '0;
  logic [4*NC-1:0]   be_v = '0;
  logic [2*NC-1:0]   resp_v;
  logic [DW*NC-1:0]  sdata_v;
  logic              mem_en, mem_we;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_wdata;
  logic [3:0]        mem_byteen;
  logic [DW-1:0]     mem_rdata = '0;

  int total = 0;
  int bad   = 0;
  int tb_cyc = 0;

  logic [31:0] sram [0:4095];
  logic        sram_init = 1'b0;

  sspm_tdm_backbone #(.NCORES(NC), .ADDR_W(AW), .DATA_W(DW), .PROT_W(4)) dut (
    .clk             (clk),
    .reset           (reset),
    .io_superMode    (super_v),
    .io_ocp_M_Cmd    (cmd_v),
    .io_ocp_M_Addr   (addr_v),
    .io_ocp_M_Data   (data_v),
    .io_ocp_M_ByteEn (be_v),
    .io_ocp_S_Resp   (resp_v),
    .io_ocp_S_Data   (sdata_v),
    .mem_en          (mem_en),
    .mem_we          (mem_we),
    .mem_addr        (mem_addr),
    .mem_wdata       (mem_wdata),
    .mem_byteen      (mem_byteen),
    .mem_rdata       (mem_rdata)
  );

  always #5 clk = ~clk;

  // Bench copy of the slot position: slot = tb_cyc % 3, restarting at reset.
  always @(posedge clk) begin
    if (reset) tb_cyc <= 0;
    else       tb_cyc <= tb_cyc + 1;
  end

  // SRAM model: each word preloaded with 0xA500_0000 | word address.
  always @(posedge clk) begin
    if (!sram_init) begin
      for (int k = 0; k < 4096; k++) sram[k] <= 32'hA500_0000 | k;
      sram_init <= 1'b1;
    end else if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_byteen[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= sram[mem_addr];
      end
    end
  end

  function automatic logic [1:0] resp_of(input int i);
    return resp_v[2*i +: 2];
  endfunction

  function automatic logic [31:0] sdata_of(input int i);
    return sdata_v[32*i +: 32];
  endfunction

  task automatic set_req(input int i, input logic [2:0] c, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] be, input logic sup);
    cmd_v[3*i +: 3]   = c;
    addr_v[32*i +: 32] = a;
    data_v[32*i +: 32] = d;
    be_v[4*i +: 4]    = be;
    super_v[i]        = sup;
  endtask

  task automatic clr_req(input int i);
    cmd_v[3*i +: 3] = C_IDLE;
  endtask

  // Advance to the first cycle whose slot equals s (inputs may then be driven).
  task automatic align_slot(input int s);
    bit hit;
    hit = 1'b0;
    for (int k = 0; k < 4 && !hit; k++) begin
      @(posedge clk); #1;
      if (tb_cyc % 3 == s) hit = 1'b1;
    end
  endtask

  // Wait (bounded) for the core's response; request must already be driven.
  task automatic wait_resp(input int core, input int max_cyc, output logic [1:0] r,
                           output logic [31:0] d, output int lat, output int n_en);
    bit done;
    done = 1'b0; r = R_NULL; d = '0; lat = 0; n_en = 0;
    for (int k = 1; k <= max_cyc && !done; k++) begin
      @(posedge clk); #1;
      if (k == 1) clr_req(core);
      @(negedge clk);
      if (mem_en) n_en++;
      if (resp_of(core) != R_NULL) begin
        r = resp_of(core); d = sdata_of(core); lat = k; done = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_req(0, C_WR, 32'h40, 32'h1234_5678, 4'hF, 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (resp_v !== '0) begin bad++; $display("FAIL rst_resp: got %h want 0", resp_v); end
    total++; if (sdata_v !== '0) begin bad++; $display("FAIL rst_sdata: got %h want 0", sdata_v); end
    total++; if (mem_en !== 1'b0) begin bad++; $display("FAIL rst_mem_en: got %b want 0", mem_en); end
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL rst_mem_we: got %b want 0", mem_we); end
    total++; if (mem_addr !== '0) begin bad++; $display("FAIL rst_mem_addr: got %h want 0", mem_addr); end
    total++; if (mem_wdata !== '0) begin bad++; $display("FAIL rst_mem_wdata: got %h want 0", mem_wdata); end
    total++; if (mem_byteen !== '0) begin bad++; $display("FAIL rst_mem_byteen: got %h want 0", mem_byteen); end
    clr_req(0);
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_single_write();
    align_slot(0);
    set_req(1, C_WR, 32'h40, 32'hDEAD_BEEF, 4'hF, 1'b0);
    @(negedge clk);
    total++; if (mem_en !== 1'b0) begin bad++; $display("FAIL sw_issue_en: got %b want 0", mem_en); end
    @(posedge clk); #1; clr_req(1);
    @(negedge clk);
    total++; if (mem_en !== 1'b1) begin bad++; $display("FAIL sw_mem_en: got %b want 1", mem_en); end
    total++; if (mem_we !== 1'b1) begin bad++; $display("FAIL sw_mem_we: got %b want 1", mem_we); end
    total++; if (mem_addr !== 12'h010) begin bad++; $display("FAIL sw_mem_addr: got %h want 010", mem_addr); end
    total++; if (mem_wdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL sw_mem_wdata: got %h want deadbeef", mem_wdata); end
    total++; if (mem_byteen !== 4'hF) begin bad++; $display("FAIL sw_mem_byteen: got %h want f", mem_byteen); end
    total++; if (resp_of(1) !== R_NULL) begin bad++; $display("FAIL sw_early_resp: got %0d want 0", resp_of(1)); end
    @(posedge clk); #1;
    @(negedge clk);
    total++; if (resp_of(1) !== R_DVA) begin bad++; $display("FAIL sw_dva: got %0d want 1", resp_of(1)); end
    total++; if (sdata_of(1) !== 32'h0) begin bad++; $display("FAIL sw_sdata: got %h want 0", sdata_of(1)); end
    total++; if (mem_en !== 1'b0) begin bad++; $display("FAIL sw_idle_slot_en: got %b want 0", mem_en); end
    total++; if (mem_addr !== 12'h010) begin bad++; $display("FAIL sw_hold_addr: got %h want 010", mem_addr); end
    @(posedge clk); #1;
    @(negedge clk);
    total++; if (resp_of(1) !== R_NULL) begin bad++; $display("FAIL sw_one_cycle_dva: got %0d want 0", resp_of(1)); end
    total++; if (sram[16] !== 32'hDEAD_BEEF) begin bad++; $display("FAIL sw_sram: got %h want deadbeef", sram[16]); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] r; logic [31:0] d; int lat, n;
    @(posedge clk); #1;
    set_req(1, C_RD, 32'h40, 32'h0, 4'hF, 1'b0);
    wait_resp(1, 6, r, d, lat, n);
    total++; if (r !== R_DVA) begin bad++; $display("FAIL rb1_resp: got %0d want 1", r); end
    total++; if (d !== 32'hDEAD_BEEF) begin bad++; $display("FAIL rb1_data: got %h want deadbeef", d); end
    total++; if (lat < 2 || lat > 4) begin bad++; $display("FAIL rb1_latency: got %0d want 2..4", lat); end
    @(posedge clk); #1;
    set_req(1, C_WR, 32'h40, 32'h0000_00FF, 4'h1, 1'b0);
    wait_resp(1, 6, r, d, lat, n);
    total++; if (r !== R_DVA) begin bad++; $display("FAIL bl_wr_resp: got %0d want 1", r); end
    total++; if (d !== 32'h0) begin bad++; $display("FAIL bl_wr_data: got %h want 0", d); end
    total++; if (n !== 1) begin bad++; $display("FAIL bl_wr_access: got %0d want 1", n); end
    @(posedge clk); #1;
    set_req(1, C_RD, 32'h40, 32'h0, 4'hF, 1'b0);
    wait_resp(1, 6, r, d, lat, n);
    total++; if (r !== R_DVA) begin bad++; $display("FAIL rb2_resp: got %0d want 1", r); end
    total++; if (d !== 32'hDEAD_BEFF) begin bad++; $display("FAIL rb2_data: got %h want deadbeff", d); end
    total++; if (lat < 2 || lat > 4) begin bad++; $display("FAIL rb2_latency: got %0d want 2..4", lat); end
  endtask

  task automatic test_contention();
    logic        exp_en   [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [11:0] exp_addr [5] = '{12'h000, 12'h080, 12'h0C0, 12'h040, 12'h000};
    logic [1:0]  exp_r0   [5] = '{R_NULL, R_NULL, R_NULL, R_NULL, R_DVA};
    logic [1:0]  exp_r1   [5] = '{R_NULL, R_NULL, R_DVA, R_NULL, R_NULL};
    logic [1:0]  exp_r2   [5] = '{R_NULL, R_NULL, R_NULL, R_DVA, R_NULL};
    int n_en;
    n_en = 0;
    align_slot(0);
    set_req(0, C_RD, 32'h100, 32'h0, 4'hF, 1'b0);
    set_req(1, C_RD, 32'h200, 32'h0, 4'hF, 1'b0);
    set_req(2, C_RD, 32'h300, 32'h0, 4'hF, 1'b0);
    for (int c = 0; c < 5; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
        if (c == 1) begin clr_req(0); clr_req(1); clr_req(2); end
      end
      @(negedge clk);
      if (mem_en) n_en++;
      total++; if (mem_en !== exp_en[c]) begin bad++; $display("FAIL ct_en c%0d: got %b want %b", c, mem_en, exp_en[c]); end
      if (exp_en[c]) begin
        total++; if (mem_addr !== exp_addr[c]) begin bad++; $display("FAIL ct_addr c%0d: got %h want %h", c, mem_addr, exp_addr[c]); end
      end
      total++; if (resp_of(0) !== exp_r0[c]) begin bad++; $display("FAIL ct_resp0 c%0d: got %0d want %0d", c, resp_of(0), exp_r0[c]); end
      total++; if (resp_of(1) !== exp_r1[c]) begin bad++; $display("FAIL ct_resp1 c%0d: got %0d want %0d", c, resp_of(1), exp_r1[c]); end
      total++; if (resp_of(2) !== exp_r2[c]) begin bad++; $display("FAIL ct_resp2 c%0d: got %0d want %0d", c, resp_of(2), exp_r2[c]); end
      if (c == 2) begin
        total++; if (sdata_of(1) !== 32'hA500_0080) begin bad++; $display("FAIL ct_data1: got %h want a5000080", sdata_of(1)); end
      end
      if (c == 3) begin
        total++; if (sdata_of(2) !== 32'hA500_00C0) begin bad++; $display("FAIL ct_data2: got %h want a50000c0", sdata_of(2)); end
      end
      if (c == 4) begin
        total++; if (sdata_of(0) !== 32'hA500_0040) begin bad++; $display("FAIL ct_data0: got %h want a5000040", sdata_of(0)); end
      end
    end
    total++; if (n_en !== 3) begin bad++; $display("FAIL ct_access_count: got %0d want 3", n_en); end
  endtask

  task automatic test_ignored_cmd();
    int n_en, n_dva;
    n_en = 0; n_dva = 0;
    align_slot(1);
    set_req(0, C_WR, 32'h20, 32'h1111_1111, 4'hF, 1'b1);
    for (int c = 0; c < 7; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
        if (c == 1) set_req(0, C_WR, 32'h24, 32'h2222_2222, 4'hF, 1'b1);
        if (c == 3) clr_req(0);
      end
      @(negedge clk);
      if (mem_en) n_en++;
      if (resp_of(0) == R_DVA) n_dva++;
      if (c == 2) begin
        total++; if (mem_addr !== 12'h008) begin bad++; $display("FAIL ig_addr: got %h want 008", mem_addr); end
        total++; if (mem_wdata !== 32'h1111_1111) begin bad++; $display("FAIL ig_wdata: got %h want 11111111", mem_wdata); end
      end
    end
    total++; if (n_en !== 1) begin bad++; $display("FAIL ig_access_count: got %0d want 1", n_en); end
    total++; if (n_dva !== 1) begin bad++; $display("FAIL ig_dva_count: got %0d want 1", n_dva); end
    total++; if (sram[9] !== 32'hA500_0009) begin bad++; $display("FAIL ig_second_not_written: got %h want a5000009", sram[9]); end
  endtask

  task automatic test_reset_midop();
    int n_en, n_r;
    n_en = 0; n_r = 0;
    align_slot(0);
    set_req(2, C_WR, 32'h500, 32'h1234_5678, 4'hF, 1'b1);
    @(posedge clk); #1;
    clr_req(2);
    #1 reset = 1'b1;
    @(negedge clk);
    total++; if (mem_en !== 1'b0) begin bad++; $display("FAIL rm_en_in_reset: got %b want 0", mem_en); end
    total++; if (resp_of(2) !== R_NULL) begin bad++; $display("FAIL rm_resp_in_reset: got %0d want 0", resp_of(2)); end
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (mem_en) n_en++;
      if (resp_of(2) != R_NULL) n_r++;
      @(posedge clk); #1;
    end
    total++; if (n_en !== 0) begin bad++; $display("FAIL rm_no_access: got %0d want 0", n_en); end
    total++; if (n_r !== 0) begin bad++; $display("FAIL rm_no_resp: got %0d want 0", n_r); end
    total++; if (sram[12'h140] !== 32'hA500_0140) begin bad++; $display("FAIL rm_sram: got %h want a5000140", sram[12'h140]); end
  endtask

  task automatic test_prot();
    logic [1:0] r; logic [31:0] d; int lat, n;
`ifdef SSPM_PROT_EN
    logic [1:0]  exp_r = R_ERR;
    int          exp_n = 0;
    logic [31:0] exp_w = 32'hA500_0002;
`else
    logic [1:0]  exp_r = R_DVA;
    int          exp_n = 1;
    logic [31:0] exp_w = 32'hCAFE_0001;
`endif
    @(posedge clk); #1;
    set_req(0, C_WR, 32'h8, 32'hCAFE_0001, 4'hF, 1'b0);
    wait_resp(0, 6, r, d, lat, n);
    total++; if (r !== exp_r) begin bad++; $display("FAIL pr_user_resp: got %0d want %0d", r, exp_r); end
    total++; if (n !== exp_n) begin bad++; $display("FAIL pr_user_access: got %0d want %0d", n, exp_n); end
    total++; if (sram[2] !== exp_w) begin bad++; $display("FAIL pr_user_sram: got %h want %h", sram[2], exp_w); end
    @(posedge clk); #1;
    set_req(0, C_WR, 32'h8, 32'hCAFE_0002, 4'hF, 1'b1);
    wait_resp(0, 6, r, d, lat, n);
    total++; if (r !== R_DVA) begin bad++; $display("FAIL pr_super_resp: got %0d want 1", r); end
    total++; if (sram[2] !== 32'hCAFE_0002) begin bad++; $display("FAIL pr_super_sram: got %h want cafe0002", sram[2]); end
    @(posedge clk); #1;
    set_req(0, C_RD, 32'h8, 32'h0, 4'hF, 1'b0);
    wait_resp(0, 6, r, d, lat, n);
    total++; if (r !== R_DVA) begin bad++; $display("FAIL pr_user_rd_resp: got %0d want 1", r); end
    total++; if (d !== 32'hCAFE_0002) begin bad++; $display("FAIL pr_user_rd_data: got %h want cafe0002", d); end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_back_to_back();
    test_contention();
    test_ignored_cmd();
    test_reset_midop();
    test_prot();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: sim time got limit reached want finish earlier");
    $fatal(1, "watchdog expired");
  end

endmodule
